// File: rtl/sha256_multiblock_core.sv
// SHA-256 / SHA-256d engine: reads an N-word message from synchronous memory,
// pads it internally, hashes block by block and writes H0..H7 back to memory.
module sha256_multiblock_core #(
  parameter int MAX_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        double_hash,
  input  logic [15:0] num_words,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [2:0] {IDLE, READ, COMPUTE, UPDATE, WRITE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t      state;
  logic [31:0] h [8];
  logic [31:0] v [8];
  logic [31:0] w [16];
  logic [15:0] msg_base, out_base;
  logic [12:0] n_words;
  logic [8:0]  b1, blk;
  logic        dbl;
  logic [6:0]  cnt;

  logic [12:0] n_clamp, g_cap, g_nxt, g_blk;
  logic [8:0]  b1_in, blk_nxt, total;
  logic        first;
  logic [31:0] pad_word, t1, t2, w_new;

  assign mem_clk = clk;

  assign n_clamp = (num_words > 16'(MAX_WORDS)) ? 13'(MAX_WORDS) : num_words[12:0];
  assign b1_in   = 9'((n_clamp + 13'd2) >> 4) + 9'd1;
  assign blk_nxt = blk + 9'd1;
  assign total   = b1 + {8'd0, dbl};
  assign first   = blk < b1;

  // READ cycle cnt captures word cnt-1 and addresses word cnt+1 of the block
  assign g_cap = {blk, cnt[3:0] - 4'd1};
  assign g_nxt = {blk, cnt[3:0] + 4'd1};
  assign g_blk = {blk_nxt, 4'd0};

  always_comb begin
    pad_word = 32'd0;
    if (g_cap < n_words)
      pad_word = mem_read_data;
    else if (g_cap == n_words)
      pad_word = 32'h8000_0000;
    else if (cnt[3:0] == 4'd0 && blk == b1 - 9'd1)
      pad_word = {14'd0, n_words, 5'd0};
  end

  assign t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[cnt[5:0]] + w[0];
  assign t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
  // w[0] is W_t; the window slides one word per round
  assign w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
               + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      done           <= 1'b1;
      mem_we         <= 1'b0;
      mem_addr       <= 16'd0;
      mem_write_data <= 32'd0;
      msg_base       <= 16'd0;
      out_base       <= 16'd0;
      n_words        <= 13'd0;
      b1             <= 9'd0;
      blk            <= 9'd0;
      dbl            <= 1'b0;
      cnt            <= 7'd0;
      for (int k = 0; k < 8; k++) begin
        h[k] <= 32'd0;
        v[k] <= 32'd0;
      end
      for (int k = 0; k < 16; k++) w[k] <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          done     <= 1'b0;
          msg_base <= message_addr;
          out_base <= output_addr;
          n_words  <= n_clamp;
          b1       <= b1_in;
          dbl      <= double_hash;
          blk      <= 9'd0;
          cnt      <= 7'd0;
          for (int k = 0; k < 8; k++) h[k] <= IV[k];
          if (n_clamp != 13'd0) mem_addr <= message_addr;
          state    <= READ;
        end
        READ: begin
          if (cnt != 7'd0 && first) w[cnt[3:0] - 4'd1] <= pad_word;
          if (cnt < 7'd15 && first && g_nxt < n_words)
            mem_addr <= msg_base + {3'd0, g_nxt};
          if (cnt == 7'd16) begin
            for (int k = 0; k < 8; k++) v[k] <= h[k];
            cnt   <= 7'd0;
            state <= COMPUTE;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        COMPUTE: begin
          v[7] <= v[6];
          v[6] <= v[5];
          v[5] <= v[4];
          v[4] <= v[3] + t1;
          v[3] <= v[2];
          v[2] <= v[1];
          v[1] <= v[0];
          v[0] <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
          w[15] <= w_new;
          if (cnt == 7'd63) begin
            cnt   <= 7'd0;
            state <= UPDATE;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        UPDATE: begin
          cnt <= 7'd0;
          if (blk_nxt < total) begin
            blk   <= blk_nxt;
            state <= READ;
            if (blk_nxt == b1) begin
              // Second pass: the block is fully known, so build it here and skip memory
              for (int k = 0; k < 8; k++) begin
                w[k] <= h[k] + v[k];
                h[k] <= IV[k];
              end
              w[8] <= 32'h8000_0000;
              for (int k = 9; k < 15; k++) w[k] <= 32'd0;
              w[15] <= 32'd256;
            end else begin
              for (int k = 0; k < 8; k++) h[k] <= h[k] + v[k];
              if (g_blk < n_words) mem_addr <= msg_base + {3'd0, g_blk};
            end
          end else begin
            for (int k = 0; k < 8; k++) h[k] <= h[k] + v[k];
            mem_we         <= 1'b1;
            mem_addr       <= out_base;
            mem_write_data <= h[0] + v[0];
            state          <= WRITE;
          end
        end
        WRITE: begin
          if (cnt == 7'd7) begin
            mem_we <= 1'b0;
            done   <= 1'b1;
            cnt    <= 7'd0;
            state  <= IDLE;
          end else begin
            cnt            <= cnt + 7'd1;
            mem_addr       <= out_base + {9'd0, cnt + 7'd1};
            mem_write_data <= h[cnt[2:0] + 3'd1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Bench for sha256_multiblock_core: known-answer table, random messages against
// a queue-based SHA-256 model, back-to-back starts and a mid-hash reset.
module tb_sha256_multiblock_core;
  localparam int MAXW = 20;

  localparam logic [31:0] IVT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic        clk = 1'b0, reset_n = 1'b1, start = 1'b0, double_hash = 1'b0;
  logic [15:0] num_words = '0, message_addr = '0, output_addr = '0;
  logic        done, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  logic [31:0] mem [65536];
  logic        tb_we = 1'b0;
  logic [15:0] tb_a = '0;
  logic [31:0] tb_d = '0;

  logic [31:0] msgbuf [64];
  int n_checks = 0, n_fail = 0;
  int we_total = 0, viol_total = 0;
  logic [15:0] mon_base = '0;
  int mon_n = 0;

  always #5 clk = ~clk;

  sha256_multiblock_core #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .double_hash(double_hash),
    .num_words(num_words), .message_addr(message_addr), .output_addr(output_addr),
    .done(done), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data));

  // synchronous memory, one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    else if (tb_we) mem[tb_a] <= tb_d;
    mem_read_data <= mem[mem_addr];
  end

  // write-cycle count and out-of-message read addresses while busy
  always @(negedge clk) begin
    if (done === 1'b0) begin
      if (mem_we) we_total++;
      else if (mon_n > 0 && int'(16'(mem_addr - mon_base)) >= mon_n) viol_total++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void sha_q(input logic [31:0] msg[$], output logic [31:0] dig[8], output int nblk);
    logic [31:0] p[$];
    logic [31:0] ww [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
    p = msg;
    p.push_back(32'h8000_0000);
    while (p.size() % 16 != 14) p.push_back(32'h0);
    p.push_back(32'h0);
    p.push_back(32'(msg.size() * 32));
    nblk = p.size() / 16;
    for (int k = 0; k < 8; k++) hv[k] = IVT[k];
    for (int bi = 0; bi < nblk; bi++) begin
      for (int t = 0; t < 16; t++) ww[t] = p[16*bi + t];
      for (int t = 16; t < 64; t++)
        ww[t] = (rr(ww[t-2], 17) ^ rr(ww[t-2], 19) ^ (ww[t-2] >> 10)) + ww[t-7]
              + (rr(ww[t-15], 7) ^ rr(ww[t-15], 18) ^ (ww[t-15] >> 3)) + ww[t-16];
      a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
      e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
      for (int t = 0; t < 64; t++) begin
        x1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + ww[t];
        x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
      end
      hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
      hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
    end
    dig = hv;
  endfunction

  function automatic void ref_hash(input int n, input bit dbl, output logic [31:0] dig[8], output int cyc);
    logic [31:0] q[$];
    int nb, nb2;
    for (int i = 0; i < ((n > MAXW) ? MAXW : n); i++) q.push_back(msgbuf[i]);
    sha_q(q, dig, nb);
    if (dbl) begin
      q.delete();
      for (int k = 0; k < 8; k++) q.push_back(dig[k]);
      sha_q(q, dig, nb2);
      nb += nb2;
    end
    cyc = 82 * nb + 8;
  endfunction

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_a = a; tb_d = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic load(input logic [15:0] ma, input int n, input logic [15:0] oa);
    for (int i = 0; i < n; i++) poke(16'(ma + i), msgbuf[i]);
    for (int k = 0; k < 8; k++) poke(16'(oa + k), 32'hDEADBEEF);
  endtask

  task automatic go_hash(input int n, input bit dbl, input logic [15:0] ma, input logic [15:0] oa,
                         output logic [31:0] dig[8], output int cyc);
    int we0, v0;
    mon_base = ma;
    mon_n = (n > MAXW) ? MAXW : n;
    we0 = we_total;
    v0 = viol_total;
    start = 1'b1; double_hash = dbl; num_words = 16'(n); message_addr = ma; output_addr = oa;
    @(posedge clk); #1;
    start = 1'b0;
    double_hash = ~dbl;
    num_words = 16'($urandom);
    message_addr = 16'($urandom);
    output_addr = 16'($urandom);
    check("done_fall", {31'd0, done}, 32'd0);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (done !== 1'b1 && cyc < 4000);
    check("done_rise", {31'd0, done}, 32'd1);
    for (int k = 0; k < 8; k++) dig[k] = mem[16'(oa + k)];
    check("we_cycles", 32'(we_total - we0), 32'd8);
    check("read_range", 32'(viol_total - v0), 32'd0);
  endtask

  typedef struct {
    int          n;
    bit          dbl;
    bit          use_w0;
    logic [31:0] w0;
    bit          known;
    logic [255:0] dig;
    int          cyc;
    logic [15:0] ma;
    logic [15:0] oa;
  } vec_t;

  vec_t tv [8];
  logic [31:0] dig [8];
  logic [31:0] expd [8];
  logic [31:0] expb [8];
  int cyc, ecyc, ecycb;

  initial begin
    tv[0] = '{0,  1'b0, 1'b0, 32'h0, 1'b1,
              256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 90, 16'h1000, 16'h8000};
    tv[1] = '{1,  1'b0, 1'b1, 32'h61626364, 1'b1,
              256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589, 90, 16'h1100, 16'h8010};
    tv[2] = '{13, 1'b0, 1'b0, 32'h0, 1'b0, 256'h0, 90,  16'h1200, 16'h8020};
    tv[3] = '{14, 1'b0, 1'b0, 32'h0, 1'b0, 256'h0, 172, 16'h1300, 16'h8030};
    tv[4] = '{20, 1'b0, 1'b0, 32'h0, 1'b0, 256'h0, 172, 16'hFFF6, 16'h8040};
    tv[5] = '{0,  1'b1, 1'b0, 32'h0, 1'b1,
              256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456, 172, 16'h1400, 16'h8050};
    tv[6] = '{25, 1'b0, 1'b0, 32'h0, 1'b0, 256'h0, 172, 16'h1500, 16'h8060};
    tv[7] = '{20, 1'b1, 1'b0, 32'h0, 1'b0, 256'h0, 254, 16'h1600, 16'h8070};

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done}, 32'd1);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    check("mem_clk", {31'd0, mem_clk}, {31'd0, clk});
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 64; j++) msgbuf[j] = $urandom;
      if (tv[i].use_w0) msgbuf[0] = tv[i].w0;
      load(tv[i].ma, tv[i].n, tv[i].oa);
      ref_hash(tv[i].n, tv[i].dbl, expd, ecyc);
      if (tv[i].known)
        for (int k = 0; k < 8; k++) expd[k] = tv[i].dig[255 - 32*k -: 32];
      go_hash(tv[i].n, tv[i].dbl, tv[i].ma, tv[i].oa, dig, cyc);
      check($sformatf("cycles v%0d", i), 32'(cyc), 32'(tv[i].cyc));
      for (int k = 0; k < 8; k++) check($sformatf("digest v%0d H%0d", i, k), dig[k], expd[k]);
    end

    // back-to-back: second start lands in the first IDLE cycle after done
    for (int j = 0; j < 64; j++) msgbuf[j] = $urandom;
    load(16'h3000, 17, 16'hA000);
    ref_hash(17, 1'b0, expd, ecyc);
    for (int j = 0; j < 64; j++) msgbuf[j] = $urandom;
    load(16'h3100, 5, 16'hA010);
    ref_hash(5, 1'b1, expb, ecycb);
    go_hash(17, 1'b0, 16'h3000, 16'hA000, dig, cyc);
    check("b2b cycles A", 32'(cyc), 32'(ecyc));
    for (int k = 0; k < 8; k++) check($sformatf("b2b digest A H%0d", k), dig[k], expd[k]);
    go_hash(5, 1'b1, 16'h3100, 16'hA010, dig, cyc);
    check("b2b cycles B", 32'(cyc), 32'(ecycb));
    for (int k = 0; k < 8; k++) check($sformatf("b2b digest B H%0d", k), dig[k], expb[k]);

    for (int r = 0; r < 6; r++) begin
      int n;
      bit dbl;
      logic [15:0] ma;
      n = int'($urandom_range(0, 25));
      dbl = 1'($urandom_range(0, 1));
      ma = 16'($urandom);
      for (int j = 0; j < 64; j++) msgbuf[j] = $urandom;
      load(ma, n, 16'(ma + 16'h4000));
      ref_hash(n, dbl, expd, ecyc);
      go_hash(n, dbl, ma, 16'(ma + 16'h4000), dig, cyc);
      check($sformatf("rand%0d cycles n=%0d d=%0d", r, n, dbl), 32'(cyc), 32'(ecyc));
      for (int k = 0; k < 8; k++) check($sformatf("rand%0d digest H%0d", r, k), dig[k], expd[k]);
    end

    // reset 50 cycles into a 20-word hash, then a clean rerun
    begin
      int we0;
      for (int j = 0; j < 64; j++) msgbuf[j] = $urandom;
      load(16'h2000, 20, 16'h9000);
      ref_hash(20, 1'b0, expd, ecyc);
      mon_base = 16'h2000;
      mon_n = 20;
      we0 = we_total;
      start = 1'b1; double_hash = 1'b0; num_words = 16'd20;
      message_addr = 16'h2000; output_addr = 16'h9000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (50) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("abort_done", {31'd0, done}, 32'd1);
      check("abort_we", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      check("abort_no_we", 32'(we_total - we0), 32'd0);
      for (int k = 0; k < 8; k++)
        check($sformatf("abort_mem H%0d", k), mem[16'(16'h9000 + k)], 32'hDEADBEEF);
      go_hash(20, 1'b0, 16'h2000, 16'h9000, dig, cyc);
      check("post_reset cycles", 32'(cyc), 32'(ecyc));
      for (int k = 0; k < 8; k++) check($sformatf("post_reset digest H%0d", k), dig[k], expd[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_multiblock_core.md
# sha256_multiblock_core

Parametrised SHA-256 engine for the bitcoin hash datapath. It reads a variable-length message of 32-bit words from word-addressed synchronous memory. Padding and the length field are generated internally, so any length from 0 to MAX_WORDS words is handled. It processes as many 512-bit blocks as needed and can optionally re-hash the digest (SHA-256d, bitcoin double hash). The 256-bit digest is written back to memory, and the block serves as the standalone hasher in place of the fixed-length engine.

## Interface
- MAX_WORDS, 20: largest accepted message length in words; legal range 1..4095.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a hash; sampled only in IDLE.
- double_hash  in  1  sampled with start; 1 = output SHA256(SHA256(msg)).
- num_words  in  16  message length in 32-bit words; sampled with start.
- message_addr  in  16  word address of message word 0; sampled with start.
- output_addr  in  16  word address for digest word H0; sampled with start.
- done  out  1  high while in IDLE (idle/result valid).
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory word address.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  read data; valid one cycle after mem_addr is presented.

## Operation
- Message is big-endian words. Bit length L = 32*N, where N = min(num_words, MAX_WORDS); values above MAX_WORDS clamp silently.
- Block count for the first pass: B1 = floor((N+2)/16) + 1. The second pass (double_hash=1) adds 1 block. Total B = B1 + double_hash.
- Padded word at global index g = 16*blk + t:
  - g < N: memory word at message_addr + g.
  - g == N: 32'h80000000.
  - t == 15 of the last block: L[31:0].
  - All other words: 0, including t == 14 (L < 2^32).
- Second-pass block contents:
  - Words 0..7: the first-pass digest H0..H7.
  - Word 8: 32'h80000000.
  - Words 9..14: 0.
  - Word 15: 32'd256.
  - H0..H7 are reinitialised to the standard IV before the second pass.
- States:
  - IDLE: wait for start. On start, latch inputs, load IV into H0..H7, go to READ.
  - READ: 17 cycles. Cycles 0..15 present the address for word t. Cycles 1..16 capture the padded word into W[t-1]. Memory is read only for g < N; otherwise mem_addr holds its last value and the data is ignored. In the second pass no memory is read. On exit, load a..h from H0..H7.
  - COMPUTE: 64 cycles, one round per cycle (t = 0..63). W runs as a rolling 16-word window: W_t = σ1(W_t-2) + W_t-7 + σ0(W_t-15) + W_t-16 for t ≥ 16.
  - UPDATE: 1 cycle, Hk += a..h (mod 2^32). If blocks remain, go to READ; otherwise go to WRITE.
  - WRITE: 8 cycles. Cycle k drives mem_we=1, mem_addr = output_addr + k, mem_write_data = Hk. Then go to IDLE.
- All additions are modulo 2^32. Address arithmetic is 16-bit and wraps past 16'hFFFF.
- start while not IDLE is ignored. Input changes after the start edge have no effect.

## Timing
- Reset values: done=1, mem_we=0, mem_addr=0, mem_write_data=0, state IDLE, H/a..h/W = 0.
- Reset asserted mid-operation aborts immediately. No further writes occur, and any partial digest already in memory is left as-is.
- done falls the cycle after the start edge. It rises exactly 82*B + 8 cycles after the start edge, which is the edge that ends the last WRITE cycle.
- mem_we is high for exactly 8 consecutive cycles per hash, never during READ/COMPUTE/UPDATE.
- Back-to-back operation: start held high in the IDLE cycle after done rises begins the next hash with no gap cycle required.
- mem_addr during a memory read cycle is message_addr + g. Read data is consumed exactly one cycle later.

## Test plan
- Empty message (num_words=0, double_hash=0) -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 at output_addr..+7; done rises 90 cycles after start.
- num_words=1, word0=32'h61626364 ("abcd") -> 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589.
- Block-count boundaries, random data, checked against a C/Python reference:
  - num_words=13 -> done after 90 cycles.
  - num_words=14 -> done after 172 cycles.
  - num_words=20 -> done after 172 cycles.
- double_hash=1, num_words=0 -> 5df6e0e2 761359d3 0a827505 8e299fcc 03815345 45f55cf4 3e41983f 5d4c9456; done after 172 cycles.
- num_words=25 with MAX_WORDS=20 -> result equals the num_words=20 result; no memory read above message_addr+19.
- Reset pulse at cycle 50 of a 20-word hash -> done=1 and mem_we=0 immediately, no writes. A subsequent start yields the correct digest.
